fp_regstat_file: RTL
====================

# fp_regstat_file

Parametrised floating-point register file with Tomasulo register-result-status tracking. Each architectural register holds a value plus a busy bit and producer tag; the issue stage renames a destination to a reservation-station tag, and broadcasts on the common data bus (CDB) retire matching tags. Two combinational read ports serve the issue stage and return the value, or the tag to wait on. Register 0 is hardwired to zero and never renamed.

## Interface
Parameters:
- DATA_W, 16, register data width
- NREG, 8, number of registers including hardwired R0
- ADDR_W, 3, register address width, must satisfy 2^ADDR_W >= NREG
- TAG_W, 3, reservation-station tag width

Ports:
- clock  in  1  single clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- issue_valid  in  1  rename request this cycle
- issue_dest  in  ADDR_W  destination register to rename
- issue_tag  in  TAG_W  producer tag assigned to issue_dest
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  TAG_W  tag of broadcasting unit
- cdb_data  in  DATA_W  result value
- flush  in  1  synchronous: clear all busy bits
- ra_addr, rb_addr  in  ADDR_W  read port A/B address
- ra_data, rb_data  out  DATA_W  register value (valid when not busy)
- ra_busy, rb_busy  out  1  operand not yet available
- ra_tag, rb_tag  out  TAG_W  producer tag to wait on (0 when not busy)
- busy_count  out  ADDR_W+1  registered number of busy registers

## Operation
- Reset (async, reset_n=0): all values 0, all busy 0, all tags 0, busy_count 0. Read outputs follow with values 0, busy 0, tag 0.
- CDB retire: on a rising edge with cdb_valid=1, every register r (r>=1) with busy[r]=1 and tag[r]=cdb_tag loads cdb_data and clears busy[r]. Several registers may match; all update in the same cycle.
- Issue rename: on a rising edge with issue_valid=1 and issue_dest!=0, busy[issue_dest]<=1 and tag[issue_dest]<=issue_tag. The value is untouched. issue_dest=0 or issue_dest>=NREG is ignored.
- Simultaneous issue and CDB on the same register: the register value loads cdb_data if the old tag matched. Rename wins the status, so busy stays 1 with tag=issue_tag.
- Flush: clears every busy bit and tag. Values are retained. It has priority over issue and CDB status updates in the same cycle. A CDB value write in the flush cycle still occurs for registers whose old tag matched.
- Reads are combinational and reflect state before the current edge; an issue in the same cycle does not affect its own operand reads.
  - Address 0 or >= NREG: data 0, busy 0, tag 0.
  - With bypass: if busy[r]=1, cdb_valid=1 and tag[r]=cdb_tag, the read returns cdb_data with busy 0 and tag 0.
- busy_count: registered population count of the busy bits after the edge's updates. Range 0..NREG-1.

## Timing
- Write latency: 1 edge. Values or status updated at edge N are visible on the read ports after edge N.
- Read path: combinational from address, state and, with bypass, the CDB inputs. No read handshake.
- busy_count updates on the same edge as the busy bits.
- reset_n asserted mid-operation clears all state immediately, independent of clock. Deassertion is synchronised externally.

## Configuration
- FPREG_CDB_BYPASS_EN defined: the same-cycle CDB forwarding on read ports described under Operation is compiled in.
- Not defined: reads reflect registered state only. A matching CDB broadcast becomes visible one edge later, and the issue stage must snoop the CDB itself.

## Test plan
- Reset with reset_n=0 mid-run after writes -> all reads return data 0, busy 0, tag 0, and busy_count 0 immediately.
- Issue dest=3 tag=5, then CDB tag=5 data=16'h3C00 -> after edge 1, rb_addr=3 gives busy 1, tag 5. After edge 2, rb_data=16'h3C00, busy 0, busy_count back to 0.
- Rename R2 and R4 both to tag 2, then CDB tag 2 data=16'h4000 -> both registers read 16'h4000, not busy.
- Same cycle: issue dest=1 tag=6 and CDB tag=3 data=16'h1234, with R1 previously tagged 3 -> R1 value becomes 16'h1234 and R1 stays busy with tag 6.
- R6 busy on tag 4 and CDB tag 4 data=16'hABCD in the same cycle as read of R6 -> with FPREG_CDB_BYPASS_EN, reads 16'hABCD, busy 0. Without it, reads busy 1, tag 4.
- Issue dest=0 tag=7, then flush with three registers busy -> R0 never busy; after flush, busy_count 0 and old values retained.

Source files
------------

// File: rtl/fp_regstat_file.sv
// Floating-point register file with Tomasulo result-status (busy bit + producer tag) per register; R0 hardwired zero.
// Latency: writes/renames land on the next rising edge, reads are combinational; optional same-cycle CDB read bypass under FPREG_CDB_BYPASS_EN.
// Backpressure: none, every issue and CDB broadcast is accepted in the cycle it is presented.
module fp_regstat_file #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3,
    parameter int TAG_W  = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ra_addr,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] ra_data,
    output logic [DATA_W-1:0] rb_data,
    output logic              ra_busy,
    output logic              rb_busy,
    output logic [TAG_W-1:0]  ra_tag,
    output logic [TAG_W-1:0]  rb_tag,
    output logic [ADDR_W:0]   busy_count
);

    localparam logic [ADDR_W:0] NREG_W = NREG[ADDR_W:0];

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              busy;
        logic [TAG_W-1:0]  tag;
    } rd_t;

    logic [DATA_W-1:0] r_val [NREG];
    logic [TAG_W-1:0]  r_tag [NREG];
    logic [NREG-1:0]   r_busy;
    logic [ADDR_W:0]   r_busy_count;

    logic [DATA_W-1:0] w_val_nxt [NREG];
    logic [TAG_W-1:0]  w_tag_nxt [NREG];
    logic [NREG-1:0]   w_busy_nxt;
    logic [NREG-1:0]   w_hit;
    logic              w_iss_ok;
    logic [ADDR_W:0]   w_busy_cnt;
    rd_t               w_rd_a;
    rd_t               w_rd_b;

    // A register matches the CDB only while it is still waiting on that tag.
    always_comb begin
        w_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            w_hit[r] = cdb_valid && r_busy[r] && (r_tag[r] == cdb_tag);
        end
    end

    assign w_iss_ok = issue_valid && (issue_dest != '0) && ({1'b0, issue_dest} < NREG_W);

    // Value follows the old-tag match; status priority is flush > rename > retire.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int r = 0; r < NREG; r++) begin
            w_val_nxt[r] = r_val[r];
            w_tag_nxt[r] = r_tag[r];
        end
        for (int r = 1; r < NREG; r++) begin
            if (w_hit[r]) begin
                w_val_nxt[r]  = cdb_data;
                w_busy_nxt[r] = 1'b0;
                w_tag_nxt[r]  = '0;
            end
            if (w_iss_ok && (issue_dest == ADDR_W'(r))) begin
                w_busy_nxt[r] = 1'b1;
                w_tag_nxt[r]  = issue_tag;
            end
            if (flush) begin
                w_busy_nxt[r] = 1'b0;
                w_tag_nxt[r]  = '0;
            end
        end
    end

    assign w_busy_cnt = (ADDR_W+1)'($countones(w_busy_nxt));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREG; r++) begin
                r_val[r] <= '0;
                r_tag[r] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                r_val[r] <= w_val_nxt[r];
                r_tag[r] <= w_tag_nxt[r];
            end
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_busy_cnt;
        end
    end

    function automatic rd_t f_read(input logic [ADDR_W-1:0] a);
        rd_t res;
        res = '0;
        for (int r = 1; r < NREG; r++) begin
            if (a == ADDR_W'(r)) begin
                res.data = r_val[r];
                res.busy = r_busy[r];
                res.tag  = r_busy[r] ? r_tag[r] : '0;
`ifdef FPREG_CDB_BYPASS_EN
                if (w_hit[r]) begin
                    res.data = cdb_data;
                    res.busy = 1'b0;
                    res.tag  = '0;
                end
`endif
            end
        end
        return res;
    endfunction

    always_comb w_rd_a = f_read(ra_addr);
    always_comb w_rd_b = f_read(rb_addr);

    assign ra_data    = w_rd_a.data;
    assign ra_busy    = w_rd_a.busy;
    assign ra_tag     = w_rd_a.tag;
    assign rb_data    = w_rd_b.data;
    assign rb_busy    = w_rd_b.busy;
    assign rb_tag     = w_rd_b.tag;
    assign busy_count = r_busy_count;

endmodule
